// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/ready/done bundle for the bit-serial subtractor.
// The ovf wire exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  ready, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output ready, done, diff, bout, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  ready, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, done, diff, bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: diff = a - b - bin, LSB first, one full-adder cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave sub
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] nb_sh;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic s;
  logic cn;
  logic last;

  // The single full-adder cell: a + ~b + carry, bit by bit.
  always_comb begin
    s    = a_sh[0] ^ nb_sh[0] ^ c;
    cn   = (a_sh[0] & nb_sh[0]) |
           (a_sh[0] & c) |
           (nb_sh[0] & c);
    last = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      nb_sh   <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (sub.start) begin
            a_sh    <= sub.a;
            nb_sh   <= ~sub.b;
            c       <= ~sub.bin;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          nb_sh  <= {1'b0, nb_sh[WIDTH-1:1]};
          c      <= cn;
          diff_q <= {s, diff_q[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last) begin
            bout_q <= ~cn;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= c ^ cn;
`endif
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign sub.ready = ready_q;
  assign sub.done  = done_q;
  assign sub.diff  = diff_q;
  assign sub.bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign sub.ovf   = ovf_q;
`endif

endmodule
